// File: rtl/uart_rx_ctrl.sv
// Receive-side byte FIFO with sticky overrun/framing status for a UART receiver.
// Optional threshold/status interrupt register is built when UART_RX_CTRL_IRQ_EN is defined.
module uart_rx_ctrl #(
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_din,
    input  logic                     rx_recv,
    input  logic                     rx_err,
    input  logic                     rx_busy,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     active,
    output logic                     irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_param
        $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and IRQ_LEVEL in 1..DEPTH");
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overrun_q, frame_err_q;

    logic          do_push, do_pop, drop;
    logic [PW-1:0] next_wr_ptr, next_rd_ptr;
    logic [CW-1:0] next_count;
    logic          next_overrun, next_frame_err;

    // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds then.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        do_pop         = 1'b0;
        do_push        = 1'b0;
        drop           = 1'b0;
        next_wr_ptr    = wr_ptr;
        next_rd_ptr    = rd_ptr;
        next_count     = count_q;
        next_overrun   = overrun_q & ~clr;
        next_frame_err = frame_err_q & ~clr;

        if (flush) begin
            next_wr_ptr = '0;
            next_rd_ptr = '0;
            next_count  = '0;
        end else begin
            do_pop  = rd_en && (count_q != '0);
            do_push = rx_recv && ((count_q != FULL_LVL) || do_pop);
            drop    = rx_recv && !do_push;
            if (do_push) next_wr_ptr = wr_ptr + PW'(1);
            if (do_pop)  next_rd_ptr = rd_ptr + PW'(1);
            if (do_push && !do_pop)      next_count = count_q + CW'(1);
            else if (do_pop && !do_push) next_count = count_q - CW'(1);
        end

        if (drop)   next_overrun   = 1'b1;
        if (rx_err) next_frame_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr      <= next_wr_ptr;
            rd_ptr      <= next_rd_ptr;
            count_q     <= next_count;
            overrun_q   <= next_overrun;
            frame_err_q <= next_frame_err;
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= rx_din;
    end

`ifdef UART_RX_CTRL_IRQ_EN
    localparam logic [CW-1:0] IRQ_THR = CW'(IRQ_LEVEL);
    logic irq_q;

    // Registered from the next-state values so irq moves on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (next_count >= IRQ_THR) | next_overrun | next_frame_err;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rd_valid  = (count_q != '0);
    assign rd_data   = rd_valid ? mem[rd_ptr] : 8'h00;
    assign count     = count_q;
    assign full      = (count_q == FULL_LVL);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign active    = rx_busy | rd_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=16, IRQ_LEVEL=8).
// irq expectations follow whether UART_RX_CTRL_IRQ_EN is defined for the build.
module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_din;
    logic       rx_recv, rx_err, rx_busy, rd_en, flush, clr;
    logic [7:0] rd_data;
    logic       rd_valid, full, overrun, frame_err, active, irq;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DEPTH(16), .IRQ_LEVEL(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_din(rx_din), .rx_recv(rx_recv), .rx_err(rx_err),
        .rx_busy(rx_busy), .rd_en(rd_en), .flush(flush), .clr(clr), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .full(full), .overrun(overrun),
        .frame_err(frame_err), .active(active), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_irq(input logic v);
        return IRQ_ON ? v : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_din  = b;
        rx_recv = 1'b1;
        tick();
        rx_recv = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_din = 8'h00; rx_recv = 1'b0; rx_err = 1'b0;
        rx_busy = 1'b0; rd_en = 1'b0; flush = 1'b0; clr = 1'b0;
        tick();
        tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_full", full, 0);
        check("rst_irq", irq, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        tick();

        // Basic ordering
        push(8'hA5);
        check("b_count1", count, 1);
        check("b_head1", rd_data, 8'hA5);
        check("b_valid1", rd_valid, 1);
        check("b_active1", active, 1);
        push(8'h3C);
        check("b_count2", count, 2);
        check("b_head2", rd_data, 8'hA5);
        pop();
        check("b_count3", count, 1);
        check("b_head3", rd_data, 8'h3C);
        pop();
        check("b_count4", count, 0);
        check("b_valid4", rd_valid, 0);
        check("b_data4", rd_data, 8'h00);
        pop();
        check("b_empty_pop", count, 0);
        check("b_active0", active, 0);
        rx_busy = 1'b1; #1;
        check("b_active_busy", active, 1);
        rx_busy = 1'b0; #1;

        // Overrun with 17 pushes
        for (int i = 0; i < 17; i++) push(8'(i));
        check("o_full", full, 1);
        check("o_count", count, 16);
        check("o_overrun", overrun, 1);
        check("o_irq", irq, exp_irq(1'b1));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("o_drain%0d", i), rd_data, 32'(i));
            pop();
        end
        check("o_empty", count, 0);
        check("o_sticky", overrun, 1);
        pulse_clr();
        check("o_clr", overrun, 0);
        check("o_clr_irq", irq, 0);

        // Simultaneous push/pop while full (also wraps both pointers)
        for (int i = 0; i < 16; i++) push(8'(i));
        rx_din = 8'hEE; rx_recv = 1'b1; rd_en = 1'b1;
        tick();
        rx_recv = 1'b0; rd_en = 1'b0;
        check("s_count", count, 16);
        check("s_overrun", overrun, 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("s_drain%0d", i), rd_data, 32'(i));
            pop();
        end
        check("s_last", rd_data, 8'hEE);
        pop();
        check("s_empty", count, 0);

        // Flush priority and clr vs set
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        check("f_count5", count, 5);
        flush = 1'b1; rx_recv = 1'b1; rd_en = 1'b1; rx_din = 8'h99;
        tick();
        flush = 1'b0; rx_recv = 1'b0; rd_en = 1'b0;
        check("f_count", count, 0);
        check("f_valid", rd_valid, 0);
        check("f_overrun", overrun, 0);
        clr = 1'b1; rx_err = 1'b1;
        tick();
        clr = 1'b0; rx_err = 1'b0;
        check("f_ferr_win", frame_err, 1);
        pulse_clr();
        check("f_ferr_clr", frame_err, 0);

        // Interrupt threshold and status
        for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
        check("i_irq7", irq, 0);
        push(8'h77);
        check("i_irq8", irq, exp_irq(1'b1));
        pop();
        check("i_irq_pop", irq, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        check("i_irq_ferr", irq, exp_irq(1'b1));
        check("i_ferr_nopush", count, 0);
        pulse_clr();
        check("i_irq_clr", irq, 0);

        // Reset mid-operation
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        for (int i = 0; i < 7; i++) pop();
        check("r_count9", count, 9);
        check("r_ovr1", overrun, 1);
        rst_n = 1'b0; rx_recv = 1'b1; rx_din = 8'hC3; rx_busy = 1'b1;
        tick();
        rst_n = 1'b1; rx_recv = 1'b0; rx_busy = 1'b0;
        check("r_count", count, 0);
        check("r_valid", rd_valid, 0);
        check("r_data", rd_data, 8'h00);
        check("r_ovr", overrun, 0);
        check("r_irq", irq, 0);
        push(8'h5A);
        check("r_push", rd_data, 8'h5A);
        check("r_push_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, receive FIFO depth in bytes; SHALL be a power of 2 and at least 2.
REQ-002 Parameter IRQ_LEVEL, default 8, FIFO fill level (1..DEPTH) at which the threshold interrupt fires.
REQ-003 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  bus clock; the block's only clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_din  in  8  received byte from the UART receiver.
- rx_recv  in  1  one-cycle pulse: rx_din valid.
- rx_err  in  1  one-cycle pulse: stop-bit (framing) error.
- rx_busy  in  1  receiver mid-frame.
- rd_en  in  1  consumer pops the head byte.
- flush  in  1  empty the FIFO.
- clr  in  1  clear sticky status flags.
- rd_data  out  8  head byte of the FIFO.
- rd_valid  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  current fill level.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky; rx_err was seen.
- active  out  1  rx_busy OR rd_valid.
- irq  out  1  interrupt request, level-sensitive.

Function
REQ-004 Push: on a clk edge with rx_recv=1, flush=0 and room available, the block SHALL write rx_din at the write pointer, advance the write pointer and increment count.
REQ-005 Latency: a byte pushed at edge N SHALL appear on rd_data with rd_valid=1 from edge N onward, visible in cycle N+1.
REQ-006 rd_valid SHALL equal (count != 0); rd_data SHALL equal mem[rd_ptr] when rd_valid=1 and 8'h00 otherwise.
REQ-007 Pop: on an edge with rd_en=1, rd_valid=1 and flush=0, the block SHALL advance the read pointer and decrement count; rd_en with rd_valid=0 SHALL be ignored.
REQ-008 Push and pop on the same edge SHALL leave count unchanged and move both pointers. This includes the full case, where the push SHALL succeed and SHALL NOT set overrun.
REQ-009 Push when full with no pop on that edge: the byte SHALL be discarded, storage and pointers SHALL stay unchanged, and overrun SHALL be set.
REQ-010 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH and never underflow.
REQ-011 rx_err=1 SHALL set frame_err; rx_err SHALL NOT push data.
REQ-012 flush=1 SHALL zero both pointers and count on that edge, taking priority over a push and a pop on the same edge. The discarded push SHALL NOT set overrun.
REQ-013 clr=1 SHALL clear overrun and frame_err. A set event on the same edge SHALL win, leaving the flag at 1.
REQ-014 full and active SHALL be combinational from registered state and rx_busy.

Reset
REQ-015 On any edge with rst_n=0, including mid-frame and mid-burst, the block SHALL set pointers, count, overrun, frame_err and irq to 0.
REQ-016 Outputs during and immediately after reset SHALL be rd_valid=0, rd_data=8'h00, full=0 and irq=0.
REQ-017 FIFO storage SHALL NOT be reset.
REQ-018 All inputs SHALL be ignored while rst_n=0.

Configuration
REQ-019 Macro UART_RX_CTRL_IRQ_EN defined: irq SHALL be a register updated each edge to (next_count >= IRQ_LEVEL) OR next_overrun OR next_frame_err, where next_* are the values being loaded on that edge, so irq tracks state with no extra cycle.
REQ-020 Macro UART_RX_CTRL_IRQ_EN undefined: irq SHALL be constant 0, no irq register SHALL be synthesized, and IRQ_LEVEL SHALL be ignored.

Verification
REQ-021 Basic order: push 8'hA5 then 8'h3C, then pulse rd_en twice.
- Required: rd_data is A5 then 3C; count goes 1, 2, 1, 0; rd_valid ends 0 and rd_data ends 8'h00.
REQ-022 Overrun: DEPTH=16; push 17 bytes 8'h00..8'h10 with no pops.
- Required: full=1, count=16, overrun=1.
- Then pop all 16: bytes are 00..0F; 8'h10 is never output.
REQ-023 Simultaneous push/pop at full: fill 16 bytes, then on one edge pulse rx_recv (8'hEE) and rd_en together.
- Required: count stays 16 and overrun stays 0.
- Draining then yields bytes 01..0F, then EE.
REQ-024 Flush/clr priority: count=5, then one edge with flush=1, rx_recv=1, rd_en=1.
- Required: count=0, rd_valid=0, overrun=0.
- Separately, clr=1 and rx_err=1 on the same edge leaves frame_err=1.
REQ-025 IRQ, with UART_RX_CTRL_IRQ_EN defined and IRQ_LEVEL=8:
- push 7 bytes: irq=0; 8th push: irq=1 after that edge; one pop: irq=0.
- rx_err pulse: irq=1; clr: irq=0.
- Without the macro: irq=0 throughout.
REQ-026 Reset mid-operation: count=9 and overrun=1, then assert rst_n=0 for one edge.
- Required: count=0, rd_valid=0, overrun=0, irq=0.
- The next push of 8'h5A is read back as 5A.
